// File: rtl/ins_mem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Holds the handshake FSM states, the wait-state counter width and the NOP fill word.
package ins_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } imem_state_e;

  localparam int unsigned WAIT_CNT_W = 4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/ins_mem_array.sv
// Word-addressed instruction store: one synchronous write port and one registered read port.
// A read and a write to the same word on the same edge returns the old word.
module ins_mem_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ins_mem_responder.sv
// Responder side of the instruction-fetch valid/ready handshake.
// Returns a stored word after WAIT_CYCLES wait states with a one-cycle ready pulse.
module ins_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  imem_clock_in,
  input  logic                  imem_reset_in,
  input  logic                  imem_valid_in,
  input  logic [ADDR_WIDTH-1:0] imem_addr_in,
  output logic                  imem_ready_out,
  output logic [DATA_WIDTH-1:0] imem_data_out,
  output logic                  imem_error_out,
  output logic                  imem_busy_out,
  input  logic                  imem_load_en_in,
  input  logic [ADDR_WIDTH-1:0] imem_load_addr_in,
  input  logic [DATA_WIDTH-1:0] imem_load_data_in
);

  import ins_mem_pkg::*;

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

  imem_state_e             r_state;
  imem_state_e             w_next;
  logic [WAIT_CNT_W-1:0]   r_cnt;
  logic [WAIT_CNT_W-1:0]   w_cnt_nxt;
  logic [DEPTH_LOG2-1:0]   r_idx;
  logic                    r_mis;
  logic                    w_latch;
  logic                    w_cap;
  logic [DEPTH_LOG2-1:0]   w_in_idx;
  logic                    w_in_mis;
  logic [DEPTH_LOG2-1:0]   w_cap_idx;
  logic                    w_cap_mis;
  logic                    r_ready;
  logic                    r_busy;
  logic                    r_err;
  logic                    r_zero;
  logic [DATA_WIDTH-1:0]   w_rdata;
  logic                    w_unused;

  assign w_in_idx = imem_addr_in[DEPTH_LOG2+1:2];
  assign w_in_mis = |imem_addr_in[1:0];

  // With zero wait states the capture happens on the accepting edge, so the
  // live request address feeds the store instead of the latched one.
  assign w_cap_idx = (r_state == ST_IDLE) ? w_in_idx : r_idx;
  assign w_cap_mis = (r_state == ST_IDLE) ? w_in_mis : r_mis;

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_latch   = 1'b0;
    w_cap     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (imem_valid_in) begin
          w_latch = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_next = ST_RESP;
            w_cap  = 1'b1;
          end else begin
            w_next    = ST_WAIT;
            w_cnt_nxt = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (!imem_valid_in) begin
          w_next    = ST_IDLE;
          w_cnt_nxt = '0;
        end else if (r_cnt == WAIT_CNT_W'(1)) begin
          w_next    = ST_RESP;
          w_cap     = 1'b1;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt - WAIT_CNT_W'(1);
        end
      end
      ST_RESP: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next    = ST_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge imem_clock_in or negedge imem_reset_in) begin
    if (!imem_reset_in) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_mis   <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_zero  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_next == ST_RESP);
      r_busy  <= (w_next != ST_IDLE);
      if (w_latch) begin
        r_idx <= w_in_idx;
        r_mis <= w_in_mis;
      end
      if (w_cap) begin
        r_err  <= w_cap_mis;
        r_zero <= w_cap_mis;
      end
    end
  end

  ins_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .i_clk   (imem_clock_in),
    .i_we    (imem_load_en_in),
    .i_waddr (imem_load_addr_in[DEPTH_LOG2+1:2]),
    .i_wdata (imem_load_data_in),
    .i_re    (w_cap),
    .i_raddr (w_cap_idx),
    .o_rdata (w_rdata)
  );

  // The store's read register has no reset; r_zero masks it after reset and on misaligned fetches.
  assign imem_data_out  = r_zero ? '0 : w_rdata;
  assign imem_ready_out = r_ready;
  assign imem_error_out = r_err;
  assign imem_busy_out  = r_busy;

  assign w_unused = ^{imem_addr_in[ADDR_WIDTH-1:DEPTH_LOG2+2],
                      imem_load_addr_in[ADDR_WIDTH-1:DEPTH_LOG2+2],
                      imem_load_addr_in[1:0]};

endmodule

// File: tb/tb_ins_mem_responder.sv
// Bench for ins_mem_responder: a zero-wait and a three-wait instance share the load port and
// are checked against an array model of the store plus the latency/handshake rules.
module tb_ins_mem_responder;

  import ins_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0, v3;
  logic [31:0] a0, a3;
  logic        ld_en;
  logic [31:0] ld_addr, ld_data;
  logic        rdy0, err0, busy0, rdy3, err3, busy3;
  logic [31:0] d0, d3;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] mem_m [16];

  always #5 clk = ~clk;

  ins_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(4), .WAIT_CYCLES(0)) dut0 (
    .imem_clock_in(clk), .imem_reset_in(rst_n), .imem_valid_in(v0), .imem_addr_in(a0),
    .imem_ready_out(rdy0), .imem_data_out(d0), .imem_error_out(err0), .imem_busy_out(busy0),
    .imem_load_en_in(ld_en), .imem_load_addr_in(ld_addr), .imem_load_data_in(ld_data));

  ins_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(4), .WAIT_CYCLES(3)) dut3 (
    .imem_clock_in(clk), .imem_reset_in(rst_n), .imem_valid_in(v3), .imem_addr_in(a3),
    .imem_ready_out(rdy3), .imem_data_out(d3), .imem_error_out(err3), .imem_busy_out(busy3),
    .imem_load_en_in(ld_en), .imem_load_addr_in(ld_addr), .imem_load_data_in(ld_data));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    if (addr % 4 != 0) return '0;
    return mem_m[int'((addr / 4) % 16)];
  endfunction

  task automatic do_load(input logic [31:0] addr, input logic [31:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    tick();
    ld_en = 1'b0;
    mem_m[int'((addr / 4) % 16)] = data;
  endtask

  // One complete fetch on the selected instance; latency must be wait states + 1.
  task automatic fetch(input int which, input logic [31:0] addr, input string tag);
    int          lat;
    int          n;
    bit          got;
    logic [31:0] exp_d;
    logic        exp_e;
    lat   = (which == 0) ? 1 : 4;
    n     = 0;
    got   = 1'b0;
    exp_d = model_word(addr);
    exp_e = (addr % 4 != 0);
    if (which == 0) begin v0 = 1'b1; a0 = addr; end
    else            begin v3 = 1'b1; a3 = addr; end
    while (!got && n < 40) begin
      tick();
      n++;
      if (n == 1) chk({tag, "/busy_first"}, (which == 0) ? busy0 : busy3, 32'd1);
      got = (which == 0) ? rdy0 : rdy3;
    end
    v0 = 1'b0; v3 = 1'b0;
    chk({tag, "/latency"}, n, lat);
    chk({tag, "/data"}, (which == 0) ? d0 : d3, exp_d);
    chk({tag, "/error"}, (which == 0) ? err0 : err3, {31'd0, exp_e});
    tick();
    chk({tag, "/ready_pulse_end"}, (which == 0) ? rdy0 : rdy3, 32'd0);
    chk({tag, "/busy_end"}, (which == 0) ? busy0 : busy3, 32'd0);
  endtask

  int          n;
  bit          seen;
  logic [31:0] la, ldv, fa;
  int          which;

  initial begin
    rst_n = 1'b0; v0 = 1'b0; v3 = 1'b0; a0 = '0; a3 = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    #12;
    chk("reset/ready0", rdy0, 0);
    chk("reset/data0", d0, 0);
    chk("reset/error0", err0, 0);
    chk("reset/busy0", busy0, 0);
    chk("reset/ready3", rdy3, 0);
    chk("reset/data3", d3, 0);
    chk("reset/busy3", busy3, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) do_load(32'(i * 4), NOP_INSTR);

    do_load(32'h8, 32'h0050_0093);
    fetch(0, 32'h8, "w0_basic");

    do_load(32'h10, 32'hDEAD_BEEF);
    v3 = 1'b1; a3 = 32'h10;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin tick(); n++; seen = rdy3; end
    chk("b2b/first_latency", n, 4);
    chk("b2b/first_data", d3, 32'hDEAD_BEEF);
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin tick(); n++; seen = rdy3; end
    chk("b2b/spacing", n, 5);
    chk("b2b/second_data", d3, 32'hDEAD_BEEF);
    v3 = 1'b0;
    tick();
    chk("b2b/busy_end", busy3, 0);

    v3 = 1'b1; a3 = 32'h8;
    tick();
    chk("abort/busy_in_wait", busy3, 1);
    tick();
    v3 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); seen |= rdy3; end
    chk("abort/no_ready", {31'd0, seen}, 0);
    chk("abort/busy", busy3, 0);
    chk("abort/data_held", d3, 32'hDEAD_BEEF);
    chk("abort/error", err3, 0);

    fetch(0, 32'h6, "w0_misaligned");
    fetch(1, 32'h13, "w3_misaligned");
    fetch(0, 32'h8, "w0_realigned");

    do_load(32'h4, 32'h0BAD_F00D);
    fetch(0, 32'h44, "wrap");

    do_load(32'h20, 32'h2222_2222);
    v0 = 1'b1; a0 = 32'h20;
    ld_en = 1'b1; ld_addr = 32'h20; ld_data = 32'h1111_1111;
    tick();
    chk("collide/ready", rdy0, 1);
    chk("collide/old_data", d0, 32'h2222_2222);
    v0 = 1'b0; ld_en = 1'b0;
    mem_m[8] = 32'h1111_1111;
    tick();
    fetch(0, 32'h20, "collide_after");

    v3 = 1'b1; a3 = 32'h30;
    tick();
    ld_en = 1'b1; ld_addr = 32'h30; ld_data = 32'hCAFE_0001;
    tick();
    ld_en = 1'b0;
    mem_m[12] = 32'hCAFE_0001;
    n = 2; seen = 1'b0;
    while (!seen && n < 40) begin tick(); n++; seen = rdy3; end
    v3 = 1'b0;
    chk("wait_load/latency", n, 4);
    chk("wait_load/data", d3, 32'hCAFE_0001);
    tick();

    v3 = 1'b1; a3 = 32'h10;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid/ready3", rdy3, 0);
    chk("rst_mid/busy3", busy3, 0);
    chk("rst_mid/data3", d3, 0);
    chk("rst_mid/error3", err3, 0);
    chk("rst_mid/data0", d0, 0);
    v3 = 1'b0;
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); seen |= rdy3; end
    chk("rst_mid/no_ready", {31'd0, seen}, 0);
    fetch(1, 32'h10, "post_reset");

    for (int i = 0; i < 24; i++) begin
      la  = 32'($urandom_range(0, 255));
      ldv = $urandom;
      do_load(la, ldv);
      fa    = ($urandom_range(0, 1) == 1) ? la : 32'($urandom_range(0, 255));
      which = int'($urandom_range(0, 1));
      fetch(which, fa, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
